// File: rtl/note_rec_player.sv
// Multi-slot note recorder/player driving a piezo with a square wave.
// Define LOOP_PLAY_EN to repeat a slot's playback until stop; default plays one pass.
module note_rec_player #(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 16,
    parameter int NUM_SLOTS  = 2,
    parameter int NOTE_TICKS = 1000,
    parameter int DIV_STEP   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_W-1:0]            inpp,
    input  logic                         rw,
    input  logic [$clog2(NUM_SLOTS)-1:0] slot_sel,
    input  logic                         note_stb,
    input  logic                         start,
    input  logic                         stop,
    output logic                         piezo,
    output logic                         busy,
    output logic                         full
);
    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int LEN_W  = $clog2(DEPTH + 1);
    localparam int TICK_W = $clog2(NOTE_TICKS + 1);
    localparam int HALF_W = DATA_W + $clog2(DIV_STEP) + 1;

    typedef enum logic [1:0] {IDLE, REC, PLAY} state_t;

    state_t              state;
    logic [SLOT_W-1:0]   slot;
    logic [LEN_W-1:0]    len [NUM_SLOTS];
    logic [IDX_W-1:0]    idx;
    logic [TICK_W-1:0]   tick;
    logic [HALF_W-1:0]   hcnt;
    logic [DATA_W-1:0]   mem [NUM_SLOTS][DEPTH];

    logic [LEN_W-1:0]    cur_len;
    logic [DATA_W-1:0]   note;
    logic [HALF_W-1:0]   half;
    logic                note_end;
    logic                last_note;
    logic                rec_wr;

    // Half-period is sized so the largest code times DIV_STEP cannot overflow.
    function automatic logic [HALF_W-1:0] tone_half(input logic [DATA_W-1:0] code);
        return HALF_W'(code) * HALF_W'(DIV_STEP);
    endfunction

    assign cur_len   = len[slot];
    assign note      = mem[slot][idx];
    assign half      = tone_half(note);
    assign note_end  = (tick == TICK_W'(NOTE_TICKS - 1));
    assign last_note = ((LEN_W'(idx) + LEN_W'(1)) == cur_len);
    assign rec_wr    = (state == REC) && note_stb && !stop && (cur_len != LEN_W'(DEPTH));

    // Note storage carries no reset; only entries below a slot's length are ever read.
    always_ff @(posedge clk) begin
        if (rec_wr)
            mem[slot][cur_len[IDX_W-1:0]] <= inpp;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            slot  <= '0;
            for (int i = 0; i < NUM_SLOTS; i++)
                len[i] <= '0;
            idx   <= '0;
            tick  <= '0;
            hcnt  <= '0;
            piezo <= 1'b0;
            busy  <= 1'b0;
            full  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        slot  <= slot_sel;
                        idx   <= '0;
                        tick  <= '0;
                        hcnt  <= '0;
                        piezo <= 1'b0;
                        if (rw) begin
                            len[slot_sel] <= '0;
                            state         <= REC;
                            busy          <= 1'b1;
                            full          <= 1'b0;
                        end else if (len[slot_sel] != '0) begin
                            state <= PLAY;
                            busy  <= 1'b1;
                        end
                    end
                end
                REC: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        full  <= 1'b0;
                    end else if (rec_wr) begin
                        len[slot] <= cur_len + LEN_W'(1);
                        full      <= ((cur_len + LEN_W'(1)) == LEN_W'(DEPTH));
                    end
                end
                PLAY: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        piezo <= 1'b0;
                    end else if (note_end) begin
                        // Note boundary: tone counter and phase restart for the next note.
                        tick  <= '0;
                        hcnt  <= '0;
                        piezo <= 1'b0;
                        if (last_note) begin
`ifdef LOOP_PLAY_EN
                            idx <= '0;
`else
                            state <= IDLE;
                            busy  <= 1'b0;
`endif
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else begin
                        tick <= tick + TICK_W'(1);
                        if (note == '0) begin
                            piezo <= 1'b0;
                        end else if (hcnt == half - HALF_W'(1)) begin
                            hcnt  <= '0;
                            piezo <= ~piezo;
                        end else begin
                            hcnt <= hcnt + HALF_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    piezo <= 1'b0;
                end
            endcase
        end
    end
endmodule
